// File: rtl/bp_resolve_queue.sv
// Branch-resolution queue: holds in-flight predictions in order, emits counter updates
// when outcomes arrive and squashes wrong-path entries. BP_RESOLVE_STATS_EN adds resolved/correct counters.
module bp_resolve_queue #(
  parameter int DEPTH  = 4,
  parameter int HIST_W = 4,
  parameter int CNT_W  = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     pred_valid,
  output logic                     pred_ready,
  input  logic                     pred_taken,
  input  logic [HIST_W-1:0]        pred_hist,
  input  logic                     res_valid,
  output logic                     res_ready,
  input  logic                     res_taken,
  output logic                     upd_valid,
  output logic [HIST_W-1:0]        upd_index,
  output logic                     upd_taken,
  output logic                     upd_mispredict,
  output logic                     flush,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [CNT_W-1:0]         mismatch
`ifdef BP_RESOLVE_STATS_EN
  ,
  output logic [CNT_W-1:0]         resolved,
  output logic [CNT_W-1:0]         correct
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_next;

  logic                r_mem_taken [DEPTH];
  logic [HIST_W-1:0]   r_mem_hist  [DEPTH];

  logic [PTR_W-1:0]    r_rptr;
  logic [PTR_W-1:0]    r_wptr;
  logic [OCC_W-1:0]    r_occ;

  logic                r_upd_valid;
  logic [HIST_W-1:0]   r_upd_index;
  logic                r_upd_taken;
  logic                r_upd_mispredict;
  logic [CNT_W-1:0]    r_mismatch;

  logic                w_pop;
  logic                w_push;
  logic                w_head_taken;
  logic [HIST_W-1:0]   w_head_hist;
  logic                w_mispredict;
  logic                w_squash;

  assign w_head_taken = r_mem_taken[r_rptr];
  assign w_head_hist  = r_mem_hist[r_rptr];
  assign w_mispredict = w_head_taken != res_taken;

  assign w_pop    = res_valid && res_ready;
  assign w_push   = pred_valid && pred_ready;
  assign w_squash = w_pop && w_mispredict;

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    pred_ready   = 1'b0;
    res_ready    = 1'b0;
    flush        = 1'b0;
    case (r_state)
      ST_RUN: begin
        res_ready  = r_occ != '0;
        // A full queue still takes a prediction when the head retires in the same cycle.
        pred_ready = (r_occ < OCC_W'(DEPTH)) || (res_valid && (r_occ != '0));
        if (w_squash) w_state_next = ST_FLUSH;
      end
      ST_FLUSH: begin
        flush        = 1'b1;
        w_state_next = ST_RUN;
      end
      default: w_state_next = ST_RUN;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values, independent of block order.
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_RUN;
    else       r_state <= w_state_next;
  end

  // NOTE: the storage array is deliberately not reset; occupancy and pointers alone decide which slots are meaningful.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_taken[r_wptr] <= pred_taken;
      r_mem_hist[r_wptr]  <= pred_hist;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rptr           <= '0;
      r_wptr           <= '0;
      r_occ            <= '0;
      r_upd_valid      <= 1'b0;
      r_upd_index      <= '0;
      r_upd_taken      <= 1'b0;
      r_upd_mispredict <= 1'b0;
      r_mismatch       <= '0;
    end else begin
      r_upd_valid      <= w_pop;
      r_upd_mispredict <= w_squash;
      if (w_pop) begin
        r_upd_index <= w_head_hist;
        r_upd_taken <= res_taken;
      end

      if (w_squash) begin
        // Younger wrong-path entries and any same-cycle push are discarded.
        r_rptr <= r_rptr + 1'b1;
        r_wptr <= r_rptr + 1'b1;
        r_occ  <= '0;
        if (r_mismatch != '1) r_mismatch <= r_mismatch + 1'b1;
      end else begin
        r_rptr <= r_rptr + PTR_W'(w_pop);
        r_wptr <= r_wptr + PTR_W'(w_push);
        case ({w_push, w_pop})
          2'b10:   r_occ <= r_occ + 1'b1;
          2'b01:   r_occ <= r_occ - 1'b1;
          default: r_occ <= r_occ;
        endcase
      end
    end
  end

`ifdef BP_RESOLVE_STATS_EN
  logic [CNT_W-1:0] r_resolved;
  logic [CNT_W-1:0] r_correct;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_resolved <= '0;
      r_correct  <= '0;
    end else if (w_pop) begin
      if (r_resolved != '1) r_resolved <= r_resolved + 1'b1;
      if (!w_mispredict && (r_correct != '1)) r_correct <= r_correct + 1'b1;
    end
  end

  assign resolved = r_resolved;
  assign correct  = r_correct;
`endif

  assign upd_valid      = r_upd_valid;
  assign upd_index      = r_upd_index;
  assign upd_taken      = r_upd_taken;
  assign upd_mispredict = r_upd_mispredict;
  assign occupancy      = r_occ;
  assign mismatch       = r_mismatch;

endmodule

// File: tb/tb_bp_resolve_queue.sv
// Self-checking bench for bp_resolve_queue: directed vector table, corner sequences and random traffic
// against a queue-based reference model. A second instance with CNT_W=4 exercises counter saturation.
module tb_bp_resolve_queue;

  localparam int DEPTH  = 4;
  localparam int HIST_W = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic pred_valid = 1'b0, pred_taken = 1'b0, res_valid = 1'b0, res_taken = 1'b0;
  logic [HIST_W-1:0] pred_hist = '0;

  logic              pred_ready, res_ready, upd_valid, upd_taken, upd_mispredict, flush;
  logic [HIST_W-1:0] upd_index;
  logic [2:0]        occupancy;
  logic [31:0]       mismatch;

  logic              s_pred_ready, s_res_ready, s_upd_valid, s_upd_taken, s_upd_mispredict, s_flush;
  logic [HIST_W-1:0] s_upd_index;
  logic [2:0]        s_occupancy;
  logic [3:0]        s_mismatch;
`ifdef BP_RESOLVE_STATS_EN
  logic [31:0] resolved, correct;
  logic [3:0]  s_resolved, s_correct;
`endif

  always #5 clk = ~clk;

  bp_resolve_queue #(.DEPTH(DEPTH), .HIST_W(HIST_W), .CNT_W(32)) u_dut (
    .clk(clk), .reset(reset),
    .pred_valid(pred_valid), .pred_ready(pred_ready), .pred_taken(pred_taken), .pred_hist(pred_hist),
    .res_valid(res_valid), .res_ready(res_ready), .res_taken(res_taken),
    .upd_valid(upd_valid), .upd_index(upd_index), .upd_taken(upd_taken), .upd_mispredict(upd_mispredict),
    .flush(flush), .occupancy(occupancy), .mismatch(mismatch)
`ifdef BP_RESOLVE_STATS_EN
    , .resolved(resolved), .correct(correct)
`endif
  );

  bp_resolve_queue #(.DEPTH(DEPTH), .HIST_W(HIST_W), .CNT_W(4)) u_small (
    .clk(clk), .reset(reset),
    .pred_valid(pred_valid), .pred_ready(s_pred_ready), .pred_taken(pred_taken), .pred_hist(pred_hist),
    .res_valid(res_valid), .res_ready(s_res_ready), .res_taken(res_taken),
    .upd_valid(s_upd_valid), .upd_index(s_upd_index), .upd_taken(s_upd_taken),
    .upd_mispredict(s_upd_mispredict),
    .flush(s_flush), .occupancy(s_occupancy), .mismatch(s_mismatch)
`ifdef BP_RESOLVE_STATS_EN
    , .resolved(s_resolved), .correct(s_correct)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an ordered list of outstanding predictions plus the expected registered outputs.
  typedef struct {
    logic              taken;
    logic [HIST_W-1:0] hist;
  } ent_t;

  ent_t              q[$];
  bit                m_flush;
  bit                m_uv, m_ut, m_um;
  logic [HIST_W-1:0] m_ui;
  longint            m_mm, m_res, m_cor;

  function automatic longint sat(input longint v, input longint max);
    return (v > max) ? max : v;
  endfunction

  task automatic model_reset();
    q.delete();
    m_flush = 0; m_uv = 0; m_ut = 0; m_um = 0; m_ui = '0;
    m_mm = 0; m_res = 0; m_cor = 0;
  endtask

  // One clock: drive inputs after the falling edge, check outputs, then advance the model past the rising edge.
  task automatic cycle(input logic pv, input logic pt, input logic [HIST_W-1:0] ph,
                       input logic rv, input logic rt);
    bit exp_pr, exp_rr, pop, push, mis;
    ent_t h;
    @(negedge clk);
    reset = 1'b0;
    pred_valid = pv; pred_taken = pt; pred_hist = ph;
    res_valid = rv;  res_taken = rt;
    #1;
    exp_rr = !m_flush && (q.size() != 0);
    exp_pr = !m_flush && ((q.size() < DEPTH) || (rv && exp_rr));
    check("pred_ready", pred_ready, exp_pr);
    check("res_ready", res_ready, exp_rr);
    check("upd_valid", upd_valid, m_uv);
    if (m_uv) begin
      check("upd_index", upd_index, m_ui);
      check("upd_taken", upd_taken, m_ut);
    end
    check("upd_mispredict", upd_mispredict, m_um);
    check("flush", flush, m_flush);
    check("occupancy", occupancy, q.size());
    check("mismatch", mismatch, m_mm);
    check("small_mismatch", s_mismatch, sat(m_mm, 15));
    check("small_occupancy", s_occupancy, q.size());
`ifdef BP_RESOLVE_STATS_EN
    check("resolved", resolved, m_res);
    check("correct", correct, m_cor);
    check("small_resolved", s_resolved, sat(m_res, 15));
    check("small_correct", s_correct, sat(m_cor, 15));
`endif
    pop  = rv && exp_rr;
    push = pv && exp_pr;
    mis  = 0;
    m_uv = pop;
    m_um = 0;
    if (pop) begin
      h = q.pop_front();
      m_ui = h.hist;
      m_ut = rt;
      mis  = h.taken != rt;
      m_um = mis;
      m_res++;
      if (mis) m_mm++;
      else     m_cor++;
    end
    if (mis)       q.delete();
    else if (push) q.push_back('{taken: pt, hist: ph});
    m_flush = mis;
  endtask

  // Reset is held across one rising edge while both handshakes are offered; reset must win.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    pred_valid = 1'b1; pred_taken = 1'($urandom); pred_hist = HIST_W'($urandom);
    res_valid = 1'b1;  res_taken = 1'($urandom);
    model_reset();
  endtask

  typedef struct {
    logic pv, pt; logic [HIST_W-1:0] ph; logic rv, rt;
    logic pr, rr, uv; logic [HIST_W-1:0] idx; logic ut, um, fl;
    int   occ; int mm;
  } vec_t;

  vec_t tbl[15];

  initial begin
    // Expected outputs are those visible during the cycle the inputs are applied.
    //          pv pt ph  rv rt  pr rr uv idx ut um fl occ mm
    tbl[0]  = '{1, 1, 5,  0, 0,  1, 0, 0, 0,  0, 0, 0, 0,  0};
    tbl[1]  = '{1, 1, 6,  0, 0,  1, 1, 0, 0,  0, 0, 0, 1,  0};
    tbl[2]  = '{1, 1, 7,  0, 0,  1, 1, 0, 0,  0, 0, 0, 2,  0};
    tbl[3]  = '{0, 0, 0,  1, 1,  1, 1, 0, 0,  0, 0, 0, 3,  0};
    tbl[4]  = '{0, 0, 0,  1, 1,  1, 1, 1, 5,  1, 0, 0, 2,  0};
    tbl[5]  = '{0, 0, 0,  1, 1,  1, 1, 1, 6,  1, 0, 0, 1,  0};
    tbl[6]  = '{0, 0, 0,  0, 0,  1, 0, 1, 7,  1, 0, 0, 0,  0};
    tbl[7]  = '{0, 0, 0,  0, 0,  1, 0, 0, 0,  0, 0, 0, 0,  0};
    tbl[8]  = '{1, 0, 1,  0, 0,  1, 0, 0, 0,  0, 0, 0, 0,  0};
    tbl[9]  = '{1, 0, 2,  0, 0,  1, 1, 0, 0,  0, 0, 0, 1,  0};
    tbl[10] = '{1, 0, 3,  0, 0,  1, 1, 0, 0,  0, 0, 0, 2,  0};
    tbl[11] = '{1, 0, 4,  1, 1,  1, 1, 0, 0,  0, 0, 0, 3,  0};
    tbl[12] = '{1, 0, 9,  1, 0,  0, 0, 1, 1,  1, 1, 1, 0,  1};
    tbl[13] = '{0, 0, 0,  0, 0,  1, 0, 0, 0,  0, 0, 0, 0,  1};
    tbl[14] = '{0, 0, 0,  0, 0,  1, 0, 0, 0,  0, 0, 0, 0,  1};

    model_reset();
    do_reset();

    // Directed table: in-order correct resolutions, then a mispredict that squashes younger entries.
    for (int i = 0; i < 15; i++) begin
      cycle(tbl[i].pv, tbl[i].pt, tbl[i].ph, tbl[i].rv, tbl[i].rt);
      check($sformatf("vec%0d_pred_ready", i), pred_ready, tbl[i].pr);
      check($sformatf("vec%0d_res_ready", i), res_ready, tbl[i].rr);
      check($sformatf("vec%0d_upd_valid", i), upd_valid, tbl[i].uv);
      if (tbl[i].uv) begin
        check($sformatf("vec%0d_upd_index", i), upd_index, tbl[i].idx);
        check($sformatf("vec%0d_upd_taken", i), upd_taken, tbl[i].ut);
      end
      check($sformatf("vec%0d_upd_mispredict", i), upd_mispredict, tbl[i].um);
      check($sformatf("vec%0d_flush", i), flush, tbl[i].fl);
      check($sformatf("vec%0d_occupancy", i), occupancy, tbl[i].occ);
      check($sformatf("vec%0d_mismatch", i), mismatch, tbl[i].mm);
    end

    // Full queue: a held prediction stalls, then a same-cycle pop and push keeps occupancy at DEPTH.
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1, 1, HIST_W'(i + 8), 0, 0);
    check("full_pred_ready", pred_ready, 0);
    check("full_occupancy", occupancy, 4);
    cycle(1, 0, 4'hc, 1, 1);
    check("full_pop_push_ready", pred_ready, 1);
    cycle(0, 0, 0, 0, 0);
    check("full_pop_push_occ", occupancy, 4);
    check("full_pop_push_upd", upd_valid, 1);

    // Outcomes offered on an empty queue are ignored.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cycle(0, 0, 0, 1, 0);
      check("empty_res_ready", res_ready, 0);
    end
    cycle(1, 1, 4'h3, 1, 0);
    cycle(0, 0, 0, 1, 1);
    check("after_push_res_ready", res_ready, 1);
    check("empty_no_update", upd_valid, 0);
    cycle(0, 0, 0, 0, 0);

    // Repeated mispredicts drive the narrow counter into saturation.
    do_reset();
    for (int i = 0; i < 18; i++) begin
      cycle(1, 0, HIST_W'(i), 0, 0);
      cycle(0, 0, 0, 1, 1);
      cycle(0, 0, 0, 0, 0);
    end
    cycle(0, 0, 0, 0, 0);
    check("small_saturated", s_mismatch, 15);
    check("wide_not_saturated", mismatch, 18);

    // Reset asserted during the flush cycle after two pushes and a mispredicted pop.
    do_reset();
    cycle(1, 0, 4'h1, 0, 0);
    cycle(1, 0, 4'h2, 0, 0);
    cycle(0, 0, 0, 1, 1);
    @(negedge clk);
    #1;
    check("preflush_flush", flush, 1);
    reset = 1'b1;
    pred_valid = 1'b1; res_valid = 1'b1;
    model_reset();
    cycle(0, 0, 0, 0, 0);
    check("midflush_flush", flush, 0);
    check("midflush_pred_ready", pred_ready, 1);
    check("midflush_occupancy", occupancy, 0);
    check("midflush_upd_valid", upd_valid, 0);

    // Random traffic against the model, biased toward correct outcomes to build queue depth.
    for (int i = 0; i < 3000; i++) begin
      logic pv, pt, rv, rt;
      pv = ($urandom_range(0, 3) != 0);
      pt = 1'($urandom);
      rv = ($urandom_range(0, 1) != 0);
      if (q.size() != 0 && $urandom_range(0, 3) != 0) rt = q[0].taken;
      else                                            rt = 1'($urandom);
      if ($urandom_range(0, 499) == 0) do_reset();
      else cycle(pv, pt, HIST_W'($urandom), rv, rt);
    end
    cycle(0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
